// File: rtl/pcm_packer_pkg.sv
// Shared types and constants for the PCM stereo packer.
package pcm_packer_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned WORD_W   = 2 * SAMPLE_W;

  localparam logic LEFT_CHANNEL  = 1'b0;
  localparam logic RIGHT_CHANNEL = 1'b1;

  typedef enum logic {WAIT_FIRST, WAIT_SECOND} packer_state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] upper;
    logic [SAMPLE_W-1:0] lower;
  } pcm_word_t;

endpackage

// File: rtl/pcm_stereo_packer_if.sv
// Sample input, word output and status bundle of the PCM packer.
// PCM_PACKER_STATS_EN adds the drop/desync counter signals.
interface pcm_stereo_packer_if #(
  parameter int unsigned FIFO_DEPTH = 64
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]      pcm_sample_i;
  logic             valid_i;
  logic             channel_i;
  logic             invalid_i;
  logic             enable_i;
  logic             dual_channel_i;
  logic             flush_i;
  logic [LVL_W-1:0] threshold_i;
  logic [31:0]      word_o;
  logic             word_valid_o;
  logic             word_ready_i;
  logic [LVL_W-1:0] level_o;
  logic             overflow_o;
  logic             interrupt_o;

`ifdef PCM_PACKER_STATS_EN
  logic [15:0]      drop_count_o;
  logic [15:0]      desync_count_o;

  modport master (
    output pcm_sample_i, valid_i, channel_i, invalid_i, enable_i, dual_channel_i,
           flush_i, threshold_i, word_ready_i,
    input  word_o, word_valid_o, level_o, overflow_o, interrupt_o,
           drop_count_o, desync_count_o
  );

  modport slave (
    input  pcm_sample_i, valid_i, channel_i, invalid_i, enable_i, dual_channel_i,
           flush_i, threshold_i, word_ready_i,
    output word_o, word_valid_o, level_o, overflow_o, interrupt_o,
           drop_count_o, desync_count_o
  );
`else
  modport master (
    output pcm_sample_i, valid_i, channel_i, invalid_i, enable_i, dual_channel_i,
           flush_i, threshold_i, word_ready_i,
    input  word_o, word_valid_o, level_o, overflow_o, interrupt_o
  );

  modport slave (
    input  pcm_sample_i, valid_i, channel_i, invalid_i, enable_i, dual_channel_i,
           flush_i, threshold_i, word_ready_i,
    output word_o, word_valid_o, level_o, overflow_o, interrupt_o
  );
`endif

endinterface

// File: rtl/pcm_packer_fifo.sv
// First-word-fall-through word FIFO with wrap-bit pointers, flush and drop detect.
module pcm_packer_fifo
  import pcm_packer_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  pcm_word_t        push_word,
  input  logic             pop,
  output pcm_word_t        head,
  output logic             not_empty,
  output logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] level_next_c,
  output logic             drop_c
);

  pcm_word_t        mem [DEPTH];
  logic [LVL_W-1:0] wr_q;
  logic [LVL_W-1:0] rd_q;
  logic             full;
  logic             pop_fire;
  logic             push_fire;

  assign level     = wr_q - rd_q;
  assign not_empty = (level != '0);
  assign full      = (level == LVL_W'(DEPTH));
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign pop_fire  = pop & not_empty & ~flush;
  assign push_fire = push & ~flush & (~full | pop_fire);
  assign drop_c    = push & ~flush & full & ~pop_fire;
  assign head      = not_empty ? mem[rd_q[AW-1:0]] : '0;

  always_comb begin
    level_next_c = level + LVL_W'(push_fire) - LVL_W'(pop_fire);
    if (flush) level_next_c = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_fire) wr_q <= wr_q + LVL_W'(1);
      if (pop_fire)  rd_q <= rd_q + LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_q[AW-1:0]] <= push_word;
  end

endmodule

// File: rtl/pcm_stereo_packer.sv
// Packs 16-bit PCM samples into 32-bit words (L/R pairs or mono pairs) feeding a FWFT FIFO.
// PCM_PACKER_STATS_EN adds saturating drop and desync counters.
module pcm_stereo_packer
  import pcm_packer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 64
) (
  input logic                clk_i,
  input logic                rst_n_i,
  pcm_stereo_packer_if.slave bus
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  packer_state_t    state_q, state_d;
  logic [15:0]      hold_q, hold_d;
  logic             dual_q;
  logic             mode_change;
  logic             push_c;
  pcm_word_t        push_word;
  pcm_word_t        head;
  logic             not_empty;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] level_next;
  logic             drop_c;
  logic             overflow_q;
  logic             interrupt_q;

  assign mode_change = (dual_q != bus.dual_channel_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= WAIT_FIRST;
      hold_q      <= '0;
      dual_q      <= 1'b0;
      overflow_q  <= 1'b0;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      dual_q      <= bus.dual_channel_i;
      overflow_q  <= drop_c;
      interrupt_q <= (bus.threshold_i != '0) && (level_next >= bus.threshold_i);
    end
  end

  // Pairing: a ch0 in WAIT_SECOND re-seeds the left half in stereo mode.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    push_c    = 1'b0;
    push_word = '{upper: bus.pcm_sample_i, lower: hold_q};
    if (bus.flush_i || !bus.enable_i || mode_change) begin
      state_d = WAIT_FIRST;
    end else if (bus.valid_i) begin
      if (bus.invalid_i) begin
        state_d = WAIT_FIRST;
      end else if (state_q == WAIT_FIRST) begin
        if (!bus.dual_channel_i || bus.channel_i == LEFT_CHANNEL) begin
          hold_d  = bus.pcm_sample_i;
          state_d = WAIT_SECOND;
        end
      end else if (bus.dual_channel_i && bus.channel_i == LEFT_CHANNEL) begin
        hold_d = bus.pcm_sample_i;
      end else begin
        push_c  = 1'b1;
        state_d = WAIT_FIRST;
      end
    end
  end

  pcm_packer_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk_i),
    .rst_n        (rst_n_i),
    .flush        (bus.flush_i),
    .push         (push_c),
    .push_word    (push_word),
    .pop          (bus.word_ready_i),
    .head         (head),
    .not_empty    (not_empty),
    .level        (level),
    .level_next_c (level_next),
    .drop_c       (drop_c)
  );

  assign bus.word_o       = head;
  assign bus.word_valid_o = not_empty;
  assign bus.level_o      = level;
  assign bus.overflow_o   = overflow_q;
  assign bus.interrupt_o  = interrupt_q;

`ifdef PCM_PACKER_STATS_EN
  logic        accept_c;
  logic        discard_c;
  logic        desync_c;
  logic [15:0] drop_cnt_q;
  logic [15:0] desync_cnt_q;

  assign accept_c  = bus.valid_i & bus.enable_i & ~bus.flush_i & ~mode_change;
  assign discard_c = accept_c & bus.invalid_i;
  assign desync_c  = accept_c & ~bus.invalid_i & bus.dual_channel_i &
                     ((state_q == WAIT_FIRST) ? (bus.channel_i == RIGHT_CHANNEL)
                                              : (bus.channel_i == LEFT_CHANNEL));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_cnt_q   <= '0;
      desync_cnt_q <= '0;
    end else if (bus.flush_i) begin
      drop_cnt_q   <= '0;
      desync_cnt_q <= '0;
    end else begin
      if ((drop_c | discard_c) && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (desync_c && desync_cnt_q != 16'hFFFF) desync_cnt_q <= desync_cnt_q + 16'd1;
    end
  end

  assign bus.drop_count_o   = drop_cnt_q;
  assign bus.desync_count_o = desync_cnt_q;
`endif

endmodule
